// File: rtl/histogram_bin_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : otsu_pkg                                                     |
// | Description : Shared types and constants for the Otsu histogram front end: |
// |               streamer state encoding, pixel/output widths and the         |
// |               per-bin beat record {i, n_i, threshold}.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package otsu_pkg;

    localparam int PIX_W     = 8;
    localparam int OUT_CNT_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t c_st_clear   = 2'd0;
    localparam state_t c_st_accum   = 2'd1;
    localparam state_t c_st_present = 2'd2;

    typedef struct packed {
        logic [PIX_W-1:0]     i;
        logic [OUT_CNT_W-1:0] n_i;
        logic [PIX_W-1:0]     threshold;
    } bin_beat_t;

endpackage : otsu_pkg
`default_nettype wire

// File: rtl/histogram_bin_streamer_hist_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hist_bank                                                    |
// | Description : NUM_BINS x COUNT_W histogram register array.                 |
// |               - clear port   : clr_en/clr_addr zero one bin per cycle      |
// |               - inc port     : inc_en/inc_addr saturating +1               |
// |               - read port    : rd_addr -> rd_data, combinational           |
// |               Clear has priority over increment; the owner never issues    |
// |               both in the same cycle.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hist_bank #(
    parameter int NUM_BINS = 256,
    parameter int COUNT_W  = 32,
    parameter int ADDR_W   = 8
) (
    input  logic               clk,
    input  logic               clr_en,
    input  logic [ADDR_W-1:0]  clr_addr,
    input  logic               inc_en,
    input  logic [ADDR_W-1:0]  inc_addr,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COUNT_W-1:0] rd_data
);

    localparam logic [COUNT_W-1:0] c_cnt_one = COUNT_W'(1);

    logic [COUNT_W-1:0] r_mem [NUM_BINS];
    logic [COUNT_W-1:0] w_inc_cur;
    logic               w_inc_sat;

    // Read-modify-write works off the live array contents, so a pixel value
    // repeated on consecutive cycles sees the previous cycle's update.
    assign w_inc_cur = r_mem[inc_addr];
    assign w_inc_sat = &w_inc_cur;
    assign rd_data   = r_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (clr_en) begin
            r_mem[clr_addr] <= '0;
        end else if (inc_en && !w_inc_sat) begin
            r_mem[inc_addr] <= w_inc_cur + c_cnt_one;
        end
    end

endmodule : hist_bank
`default_nettype wire

// File: rtl/histogram_bin_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : histogram_bin_streamer                                       |
// | Description : Builds a grey-level histogram from a pixel stream, then for  |
// |               every threshold T_FIRST..T_LAST streams all bins            |
// |               (i, n_i, threshold) over a valid/ready handshake, and        |
// |               finally clears itself for the next frame.                    |
// | Ports       : clk, reset (sync, active-high)                               |
// |               pixel_valid/pixel/frame_end  - pixel input, accum_ready      |
// |               bin_valid/bin_ready/i/n_i/threshold - per-bin output         |
// |               pass_done/sweep_done - end-of-pass / end-of-sweep pulses     |
// |               busy - high whenever pixels are not being accepted           |
// | Options     : HIST_SKIP_ZERO_EN - skip bins whose count is zero            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module histogram_bin_streamer
    import otsu_pkg::*;
#(
    parameter int NUM_BINS = 256,
    parameter int COUNT_W  = 32,
    parameter int T_FIRST  = 0,
    parameter int T_LAST   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pixel_valid,
    input  logic [PIX_W-1:0]     pixel,
    input  logic                 frame_end,
    output logic                 accum_ready,
    output logic                 bin_valid,
    input  logic                 bin_ready,
    output logic [PIX_W-1:0]     i,
    output logic [OUT_CNT_W-1:0] n_i,
    output logic [PIX_W-1:0]     threshold,
    output logic                 pass_done,
    output logic                 sweep_done,
    output logic                 busy
);

    localparam int               c_addr_w   = $clog2(NUM_BINS);
    localparam logic [PIX_W-1:0] c_last_bin = PIX_W'(NUM_BINS - 1);
    localparam logic [PIX_W-1:0] c_t_first  = PIX_W'(T_FIRST);
    localparam logic [PIX_W-1:0] c_t_last   = PIX_W'(T_LAST);
    localparam logic [PIX_W-1:0] c_one      = PIX_W'(1);
    localparam logic [PIX_W:0]   c_num_bins = (PIX_W + 1)'(NUM_BINS);

    // Registered state
    state_t           r_state;
    logic [PIX_W-1:0] r_clr_idx;
    logic [PIX_W-1:0] r_i;
    logic [PIX_W-1:0] r_thr;
    logic             r_pass_done;
    logic             r_sweep_done;

    // Next-state
    state_t           w_state_nxt;
    logic [PIX_W-1:0] w_clr_idx_nxt;
    logic [PIX_W-1:0] w_i_nxt;
    logic [PIX_W-1:0] w_thr_nxt;
    logic             w_pass_nxt;
    logic             w_sweep_nxt;

    // Datapath
    logic [COUNT_W-1:0] w_rd_data;
    logic               w_pix_in_range;
    logic               w_inc_en;
    logic               w_clr_en;
    logic               w_present;
    logic               w_skip;
    logic               w_bin_valid;
    logic               w_xfer;
    logic               w_advance;
    bin_beat_t          w_beat;

    assign w_pix_in_range = ({1'b0, pixel} < c_num_bins);
    assign w_clr_en       = (r_state == c_st_clear);
    assign w_inc_en       = (r_state == c_st_accum) && pixel_valid && w_pix_in_range;
    assign w_present      = (r_state == c_st_present);

    hist_bank #(
        .NUM_BINS (NUM_BINS),
        .COUNT_W  (COUNT_W),
        .ADDR_W   (c_addr_w)
    ) u_hist_bank (
        .clk      (clk),
        .clr_en   (w_clr_en),
        .clr_addr (r_clr_idx[c_addr_w-1:0]),
        .inc_en   (w_inc_en),
        .inc_addr (pixel[c_addr_w-1:0]),
        .rd_addr  (r_i[c_addr_w-1:0]),
        .rd_data  (w_rd_data)
    );

`ifdef HIST_SKIP_ZERO_EN
    // Empty bins are stepped over at one per cycle without a handshake.
    assign w_skip = w_present && (w_rd_data == '0);
`else
    assign w_skip = 1'b0;
`endif

    // The histogram is frozen while presenting and r_i only moves on an
    // advance, so everything presented holds until the beat is taken.
    assign w_bin_valid = w_present && !w_skip;
    assign w_xfer      = w_bin_valid && bin_ready;
    assign w_advance   = w_present && (w_xfer || w_skip);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_clear;
            r_clr_idx    <= '0;
            r_i          <= '0;
            r_thr        <= c_t_first;
            r_pass_done  <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_idx    <= w_clr_idx_nxt;
            r_i          <= w_i_nxt;
            r_thr        <= w_thr_nxt;
            r_pass_done  <= w_pass_nxt;
            r_sweep_done <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_i_nxt       = r_i;
        w_thr_nxt     = r_thr;
        w_pass_nxt    = 1'b0;
        w_sweep_nxt   = 1'b0;

        case (r_state)
            c_st_clear: begin
                if (r_clr_idx == c_last_bin) begin
                    w_clr_idx_nxt = '0;
                    w_state_nxt   = c_st_accum;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + c_one;
                end
            end

            c_st_accum: begin
                // A pixel arriving with frame_end is still counted by the
                // bank this cycle; only the state moves on.
                if (frame_end) begin
                    w_state_nxt = c_st_present;
                    w_i_nxt     = '0;
                    w_thr_nxt   = c_t_first;
                end
            end

            c_st_present: begin
                if (w_advance) begin
                    if (r_i != c_last_bin) begin
                        w_i_nxt = r_i + c_one;
                    end else begin
                        w_i_nxt    = '0;
                        w_pass_nxt = 1'b1;
                        if (r_thr < c_t_last) begin
                            w_thr_nxt = r_thr + c_one;
                        end else begin
                            w_sweep_nxt = 1'b1;
                            w_state_nxt = c_st_clear;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt   = c_st_clear;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    assign w_beat.i         = r_i;
    assign w_beat.n_i       = w_bin_valid ? OUT_CNT_W'(w_rd_data) : '0;
    assign w_beat.threshold = r_thr;

    assign accum_ready = (r_state == c_st_accum);
    assign busy        = (r_state != c_st_accum);
    assign bin_valid   = w_bin_valid;
    assign i           = w_beat.i;
    assign n_i         = w_beat.n_i;
    assign threshold   = w_beat.threshold;
    assign pass_done   = r_pass_done;
    assign sweep_done  = r_sweep_done;

endmodule : histogram_bin_streamer
`default_nettype wire

// File: tb/tb_histogram_bin_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_histogram_bin_streamer                                    |
// | Description : Randomized self-checking bench for histogram_bin_streamer.   |
// |               A behavioural histogram (int array) predicts every beat of   |
// |               every pass; pulses, clear timing and reset are checked too.  |
// |               Honours HIST_SKIP_ZERO_EN in its expectations.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_histogram_bin_streamer;

    localparam int NB    = 16;
    localparam int CW    = 4;
    localparam int TF    = 3;
    localparam int TL    = 5;
    localparam int NPASS = TL - TF + 1;
    localparam int SAT   = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_valid;
    logic [7:0]  pixel;
    logic        frame_end;
    logic        accum_ready;
    logic        bin_valid;
    logic        bin_ready;
    logic [7:0]  i;
    logic [31:0] n_i;
    logic [7:0]  threshold;
    logic        pass_done;
    logic        sweep_done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int m_hist [NB];
    int g_pix [$];

    typedef struct {
        int i;
        int n;
        int t;
    } beat_t;

    always #5 clk = ~clk;

    histogram_bin_streamer #(
        .NUM_BINS (NB),
        .COUNT_W  (CW),
        .T_FIRST  (TF),
        .T_LAST   (TL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .frame_end   (frame_end),
        .accum_ready (accum_ready),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .i           (i),
        .n_i         (n_i),
        .threshold   (threshold),
        .pass_done   (pass_done),
        .sweep_done  (sweep_done),
        .busy        (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pixel-side activity while the block is not accumulating; must be ignored.
    task automatic drive_noise();
        pixel_valid = 1'($urandom % 2);
        pixel       = 8'($urandom_range(0, 255));
        frame_end   = ($urandom % 6 == 0);
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++) m_hist[b] = 0;
    endtask

    // Counts cycles from the current one until accum_ready; a full clear takes NB.
    task automatic wait_ready(input string tag);
        int n = 0;
        check({tag, "_busy"}, busy, 1);
        while (accum_ready !== 1'b1 && n < NB + 8) begin
            drive_noise();
            bin_ready = 1'($urandom % 2);
            tick();
            n++;
        end
        pixel_valid = 1'b0;
        frame_end   = 1'b0;
        check({tag, "_clear_cycles"}, n, NB);
    endtask

    task automatic run_frame();
        for (int k = 0; k < g_pix.size(); k++) begin
            if (k == 0) begin
                check("accum_ready", accum_ready, 1);
                check("accum_busy", busy, 0);
                check("accum_valid", bin_valid, 0);
            end
            pixel_valid = (g_pix[k] >= 0);
            pixel       = 8'(g_pix[k] < 0 ? 0 : g_pix[k]);
            frame_end   = (k == g_pix.size() - 1);
            if (g_pix[k] >= 0 && g_pix[k] < NB && m_hist[g_pix[k]] < SAT)
                m_hist[g_pix[k]]++;
            tick();
        end
        pixel_valid = 1'b0;
        frame_end   = 1'b0;
        check("present_i0", i, 0);
        check("present_thr0", threshold, TF);
        check("present_busy", busy, 1);
    endtask

    task automatic random_frame();
        int n;
        int v;
        g_pix.delete();
        n = $urandom_range(1, 40);
        for (int k = 0; k < n; k++) begin
            if ($urandom % 5 == 0)      v = -1;
            else if ($urandom % 6 == 0) v = $urandom_range(NB, 255);
            else                        v = $urandom_range(0, NB - 1);
            g_pix.push_back(v);
        end
    endtask

    // Streams one frame's sweep. abort_t >= 0 pulses reset when the beat
    // (abort_t, abort_i) is on offer.
    task automatic run_present(input bit stall, input int abort_t, input int abort_i);
        beat_t q [$];
        beat_t b;
        int    passes    = 0;
        int    sweeps    = 0;
        int    stall_cnt = 0;
        int    cyc       = 0;
        bit    exp_pass  = 1'b0;
        bit    exp_sweep = 1'b0;
        bit    done      = 1'b0;
        bit    aborted   = 1'b0;

        for (int t = TF; t <= TL; t++) begin
            for (int k = 0; k < NB; k++) begin
`ifdef HIST_SKIP_ZERO_EN
                if (m_hist[k] == 0) continue;
`endif
                b.i = k; b.n = m_hist[k]; b.t = t;
                q.push_back(b);
            end
        end

        while (!done && !aborted && cyc < 4000) begin
`ifndef HIST_SKIP_ZERO_EN
            check("pass_done", pass_done, exp_pass);
            check("sweep_done", sweep_done, exp_sweep);
`endif
            exp_pass  = 1'b0;
            exp_sweep = 1'b0;
            if (pass_done === 1'b1) passes++;
            if (sweep_done === 1'b1) begin
                sweeps++;
                done = 1'b1;
                check("sweep_with_pass", pass_done, 1);
                check("sweep_valid_low", bin_valid, 0);
                check("beats_left", q.size(), 0);
            end else if (bin_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("extra_beat", 1, 0);
                    bin_ready = 1'b1;
                end else if (abort_t >= 0 && q[0].t == abort_t && q[0].i == abort_i) begin
                    aborted   = 1'b1;
                    bin_ready = 1'b1;
                    reset     = 1'b1;
                    drive_noise();
                    tick();
                    check("rst_valid", bin_valid, 0);
                    check("rst_i", i, 0);
                    check("rst_n_i", n_i, 0);
                    check("rst_thr", threshold, TF);
                    check("rst_pass", pass_done, 0);
                    check("rst_busy", busy, 1);
                    reset = 1'b0;
                end else begin
                    check("beat_i", i, q[0].i);
                    check("beat_n_i", n_i, q[0].n);
                    check("beat_thr", threshold, q[0].t);
                    check("beat_busy", busy, 1);
                    if (stall && q[0].i == 5 && q[0].t == TF && stall_cnt < 7) begin
                        bin_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        bin_ready = ($urandom % 4 != 0);
                    end
                    if (bin_ready) begin
                        b = q.pop_front();
                        if (b.i == NB - 1) begin
                            exp_pass  = 1'b1;
                            exp_sweep = (b.t == TL);
                        end
                    end
                end
            end else begin
`ifndef HIST_SKIP_ZERO_EN
                check("valid_held", bin_valid, 1);
`endif
                bin_ready = 1'($urandom % 2);
            end
            if (!aborted && !done) begin
                drive_noise();
                tick();
                cyc++;
            end
        end

        if (!aborted) begin
            check("sweep_seen", done, 1);
            check("pass_count", passes, NPASS);
            check("sweep_count", sweeps, 1);
            if (stall) check("stall_cycles", stall_cnt, 7);
        end
        model_clear();
    endtask

    initial begin
        reset       = 1'b1;
        pixel_valid = 1'b0;
        pixel       = '0;
        frame_end   = 1'b0;
        bin_ready   = 1'b0;
        model_clear();
        repeat (3) tick();

        check("reset_accum_ready", accum_ready, 0);
        check("reset_bin_valid", bin_valid, 0);
        check("reset_i", i, 0);
        check("reset_n_i", n_i, 0);
        check("reset_thr", threshold, TF);
        check("reset_pass", pass_done, 0);
        check("reset_sweep", sweep_done, 0);
        check("reset_busy", busy, 1);
        reset = 1'b0;
        wait_ready("init");

        // Repeated pixels back-to-back, last one with frame_end; stall at i=5.
        g_pix = '{5, 5, 5, 12};
        run_frame();
        run_present(1'b1, -1, 0);
        wait_ready("f1");

        // Saturation plus an out-of-range pixel.
        g_pix.delete();
        for (int k = 0; k < 20; k++) g_pix.push_back(3);
        g_pix.push_back(255);
        g_pix.push_back(9);
        run_frame();
        run_present(1'b0, -1, 0);
        wait_ready("f2");

        for (int f = 0; f < 3; f++) begin
            random_frame();
            run_frame();
            run_present(1'b0, -1, 0);
            wait_ready("frnd");
        end

        // Reset in the middle of the second pass.
        g_pix = '{1, 2, 3, 4, 10, 10};
        run_frame();
        run_present(1'b0, TF + 1, 10);
        wait_ready("rst");

        g_pix = '{7};
        run_frame();
        run_present(1'b0, -1, 0);
        wait_ready("f7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_histogram_bin_streamer
`default_nettype wire

// File: doc/histogram_bin_streamer.md
Name: histogram_bin_streamer

Overview:
- Source end of the per-bin histogram interface (i, n_i, threshold) read by the class-weight/probability accumulators of the Otsu thresholding datapath.
- Builds a grey-level histogram from an incoming pixel stream.
- After frame end, sweeps every candidate threshold. For each threshold it streams all bins with a valid/ready handshake, then clears itself for the next frame.

Parameters:
- NUM_BINS, 256, number of histogram bins; 2..256.
- COUNT_W, 32, bin counter width; counters saturate.
- T_FIRST, 0, first threshold swept.
- T_LAST, 255, last threshold swept; T_LAST >= T_FIRST.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_valid  in  1  pixel qualifier
- pixel  in  8  grey level; values >= NUM_BINS are ignored
- frame_end  in  1  single-cycle pulse; closes accumulation
- accum_ready  out  1  high while pixels are accepted
- bin_valid  out  1  i/n_i/threshold are valid
- bin_ready  in  1  consumer accepts the current bin
- i  out  8  bin index
- n_i  out  32  bin count, zero-extended from COUNT_W
- threshold  out  8  current threshold
- pass_done  out  1  one-cycle pulse; last bin of a threshold pass transferred
- sweep_done  out  1  one-cycle pulse; last pass of the sweep complete
- busy  out  1  high in any state except ACCUM

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high.
- Storage: NUM_BINS x COUNT_W register array with combinational read, so back-to-back identical pixels count correctly.
- States: CLEAR, ACCUM, PRESENT.
- Reset values: state=CLEAR; clear index=0; accum_ready=0; bin_valid=0; i=0; n_i=0; threshold=T_FIRST; pass_done=0; sweep_done=0; busy=1.
- Reset asserted in any state, including mid-sweep or mid-handshake, behaves identically: immediate return to CLEAR, pending bin dropped.
- CLEAR:
  - Zeroes one bin per cycle, index 0..NUM_BINS-1.
  - After NUM_BINS cycles, go to ACCUM.
  - accum_ready rises on cycle NUM_BINS+1 after reset release.
- ACCUM:
  - accum_ready=1, busy=0.
  - Each cycle with pixel_valid and pixel<NUM_BINS: hist[pixel] += 1, saturating at 2^COUNT_W-1.
  - frame_end: go to PRESENT with i=0, threshold=T_FIRST.
  - pixel_valid together with frame_end in the same cycle: that pixel is counted.
- Outside ACCUM: pixel_valid is ignored and frame_end is ignored.
- PRESENT outputs:
  - bin_valid=1.
  - n_i = hist[i], zero-extended.
  - bin_valid, i, n_i and threshold are held stable until bin_valid && bin_ready.
  - bin_valid is never withdrawn without a transfer.
- PRESENT on transfer:
  - If i < NUM_BINS-1: i <= i+1; bin_valid stays high, giving one bin per cycle under continuous ready.
  - If i == NUM_BINS-1: pass_done pulses next cycle.
    - threshold < T_LAST: threshold <= threshold+1, i <= 0.
    - threshold == T_LAST: sweep_done pulses with pass_done, bin_valid <= 0, go to CLEAR.
- Total transfers per frame: NUM_BINS*(T_LAST-T_FIRST+1).
- bin_ready while bin_valid=0 has no effect.
- Histogram contents are frozen during PRESENT.

Optional Feature:
- Macro: HIST_SKIP_ZERO_EN.
- Defined:
  - In PRESENT, bins with hist[i]==0 are not presented.
  - bin_valid stays low and i advances one per cycle.
  - End-of-pass logic (pass_done, threshold step, sweep_done) still fires when the last bin is passed, whether transferred or skipped.
  - An all-zero histogram yields only pass_done/sweep_done pulses.
- Undefined: every bin is presented, including zero counts.

Decomposition:
- Shared package otsu_pkg:
  - state enum (CLEAR, ACCUM, PRESENT)
  - PIX_W=8 and OUT_CNT_W=32 constants
  - bin-beat struct {i, n_i, threshold}
- One natural sub-module: hist_bank, the register array with clear port, saturating increment port and combinational read port.
- The FSM and sweep counters stay in the top level.

Test Plan:
- Reset release -> accum_ready=0 for 256 cycles, 1 on cycle 257; all outputs at reset values.
- NUM_BINS=256, T_FIRST=T_LAST=10; pixels 5,5,5,200 back-to-back, frame_end with 200; bin_ready=1 -> 256 beats:
  - n_i=3 at i=5, n_i=1 at i=200, all others 0, threshold=10 throughout.
  - pass_done and sweep_done pulse together after i=255.
- T_FIRST=3, T_LAST=4; bin_ready=0 for 7 cycles while i=5 -> i, n_i, threshold and bin_valid stable for all 7 cycles.
  - 512 beats total; pass_done pulses twice; sweep_done pulses once; threshold 3 then 4.
- COUNT_W=4; 20 pixels of value 3; pixel 255 with pixel_valid while busy -> n_i=15 at i=3; the busy-time pixel is not counted in the next frame.
- Reset pulsed mid-sweep at i=100 -> next cycle bin_valid=0; 256-cycle clear; a fresh frame of one pixel value 7 gives n_i=1 at i=7 only.
- HIST_SKIP_ZERO_EN defined, pixels 5,200, T_FIRST=T_LAST=0 -> exactly 2 beats (i=5, i=200); pass_done and sweep_done pulse once after bin 255 is skipped.
